// File: rtl/strobe_gen_pkg.sv
// Shared types and default widths for the enable-strobe generator.
package strobe_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int PER_W_DEF = 8;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/strobe_tmr.sv
// Loadable down-counter holding the strobe spacing timer; flags when it reads zero.
module strobe_tmr #(
   parameter int PER_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [PER_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [PER_W-1:0] tmr_reg;

   // Load wins over decrement; the counter parks at zero rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_reg <= '0;
      end else if (load) begin
         tmr_reg <= load_val;
      end else if (dec && (tmr_reg != '0)) begin
         tmr_reg <= tmr_reg - PER_W'(1);
      end
   end

   assign zero = (tmr_reg == '0);

endmodule

// File: rtl/strobe_gen.sv
// Programmable enable-strobe generator: accepts a period/count configuration and
// emits single-cycle en strobes, finite bursts end with a one-cycle done pulse.
module strobe_gen
   import strobe_gen_pkg::*;
#(
   parameter int PER_W = PER_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PER_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic             stop,
   output logic             en,
   output logic             busy,
   output logic             done
);

   state_t           state_reg, state_next;
   logic [PER_W-1:0] period_reg, period_next;
   logic [CNT_W-1:0] rem_reg, rem_next;
   logic             done_reg, done_next;
   logic             tmr_load;
   logic [PER_W-1:0] tmr_load_val;
   logic             tmr_zero;
   logic             run_last;

   strobe_tmr #(.PER_W(PER_W)) u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (state_reg == RUN),
      .zero     (tmr_zero)
   );

   // rem of 1 only occurs in a finite run, so it marks the final strobe.
   assign run_last = (rem_reg == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         period_reg <= '0;
         rem_reg    <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         period_reg <= period_next;
         rem_reg    <= rem_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      period_next  = period_reg;
      rem_next     = rem_reg;
      done_next    = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = period_reg;
      case (state_reg)
         IDLE: begin
            if (cfg_valid) begin
               state_next   = RUN;
               period_next  = cfg_period;
               rem_next     = cfg_count;
               tmr_load     = 1'b1;
               tmr_load_val = cfg_period;
            end
         end
         RUN: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (rem_reg != '0) begin
                  rem_next = rem_reg - CNT_W'(1);
               end
            end
            // An abort takes priority over normal completion and never raises done.
            if (stop) begin
               state_next = IDLE;
            end else if (tmr_zero && run_last) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign cfg_ready = (state_reg == IDLE);
   assign busy      = (state_reg == RUN);
   assign en        = (state_reg == RUN) && tmr_zero;
   assign done      = done_reg;

   property p_en_busy;
      @(posedge clk) disable iff (!rst_n) en |-> busy;
   endproperty
   property p_ready_busy;
      @(posedge clk) disable iff (!rst_n) cfg_ready == !busy;
   endproperty
   property p_done_pulse;
      @(posedge clk) disable iff (!rst_n) done |=> !done;
   endproperty
   property p_en_single;
      @(posedge clk) disable iff (!rst_n) (busy && en && (period_reg != '0)) |=> !en;
   endproperty
   property p_reset;
      @(posedge clk) !rst_n |=> !busy && !en;
   endproperty
   property p_known;
      @(posedge clk) disable iff (!rst_n) !$isunknown({cfg_ready, en, busy, done});
   endproperty

   a_en_busy:    assert property (p_en_busy);
   c_en_busy:    cover property (p_en_busy);
   a_ready_busy: assert property (p_ready_busy);
   c_ready_busy: cover property (p_ready_busy);
   a_done_pulse: assert property (p_done_pulse);
   c_done_pulse: cover property (p_done_pulse);
   a_en_single:  assert property (p_en_single);
   c_en_single:  cover property (p_en_single);
   a_reset:      assert property (p_reset);
   c_reset:      cover property (p_reset);
   a_known:      assert property (p_known);
   c_known:      cover property (p_known);

endmodule

// File: tb/tb_strobe_gen.sv
// Scoreboard bench for strobe_gen: expected per-cycle outputs are queued from the
// strobe timing formula when a run is launched and compared cycle by cycle.
module tb_strobe_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_period;
   logic [7:0] cfg_count;
   logic       stop;
   logic       en;
   logic       busy;
   logic       done;

   typedef struct {
      logic [3:0] v;   // {en, busy, done, cfg_ready}
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   ctr      = 0;

   strobe_gen #(.PER_W(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_count  (cfg_count),
      .stop       (stop),
      .en         (en),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Downstream enable-driven counter.
   always @(posedge clk) begin
      if (en) ctr <= ctr + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_idle(input string name, input int n);
      exp_t e;
      for (int c = 1; c <= n; c++) begin
         e.v   = 4'b0001;
         e.tag = $sformatf("%s c%0d", name, c);
         exp_q.push_back(e);
      end
   endtask

   // Strobe k lands in cycle k*(P+1) after the handshake edge; a finite run ends
   // with a done cycle, a stop at cycle S ends with a plain idle cycle S+1.
   task automatic push_run(input string name, input int p, input int n, input int stop_at,
                           input int limit, output int len);
      exp_t e;
      int   last_str;
      int   end_c;
      bit   stopped;
      last_str = (n != 0) ? n * (p + 1) : 0;
      stopped  = (stop_at != 0) && ((n == 0) || (stop_at < last_str));
      end_c    = stopped ? stop_at : last_str;
      len      = end_c + 1;
      if (limit != 0 && limit < len) len = limit;
      for (int c = 1; c <= len; c++) begin
         if (c <= end_c) e.v = {((c % (p + 1)) == 0), 1'b1, 1'b0, 1'b0};
         else            e.v = {1'b0, 1'b0, !stopped, 1'b1};
         e.tag = $sformatf("%s c%0d", name, c);
         exp_q.push_back(e);
      end
      $display("run %s p=%0d n=%0d stop_at=%0d cycles=%0d", name, p, n, stop_at, len);
   endtask

   task automatic run_cycles(input int n, input int drop_valid_at, input int stop_at);
      exp_t e;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check(e.tag, 32'({en, busy, done, cfg_ready}), 32'(e.v));
         end
         if (c == drop_valid_at) cfg_valid = 1'b0;
         stop = (c == stop_at);
      end
   endtask

   task automatic start_cfg(input int p, input int n);
      cfg_period = 8'(p);
      cfg_count  = 8'(n);
      cfg_valid  = 1'b1;
   endtask

   initial begin
      int len;
      int c0;
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_count  = '0;
      stop       = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({en, busy, done, cfg_ready}), 32'h1);
      rst_n = 1'b1;
      push_idle("idle", 10);
      run_cycles(10, 0, 0);

      c0 = ctr;
      start_cfg(3, 4);
      push_run("p3n4", 3, 4, 0, 0, len);
      run_cycles(len, 1, 0);
      check("p3n4_counter", 32'(ctr - c0), 32'd4);

      c0 = ctr;
      start_cfg(0, 0);
      push_run("cont_stop", 0, 0, 20, 0, len);
      run_cycles(len, 1, 20);
      check("cont_counter", 32'(ctr - c0), 32'd20);

      c0 = ctr;
      start_cfg(2, 5);
      push_run("stop_strobe", 2, 5, 6, 0, len);
      run_cycles(len, 1, 6);
      check("stop_strobe_counter", 32'(ctr - c0), 32'd2);

      c0 = ctr;
      start_cfg(1, 2);
      for (int r = 0; r < 3; r++) push_run($sformatf("b2b%0d", r), 1, 2, 0, 0, len);
      run_cycles(3 * len, 3 * len, 0);
      push_idle("b2b_idle", 3);
      run_cycles(3, 0, 0);
      check("b2b_counter", 32'(ctr - c0), 32'd6);

      start_cfg(255, 1);
      push_run("pmax", 255, 1, 0, 0, len);
      run_cycles(len, 1, 0);

      c0 = ctr;
      start_cfg(0, 255);
      push_run("nmax", 0, 255, 0, 0, len);
      run_cycles(len, 1, 0);
      check("nmax_counter", 32'(ctr - c0), 32'd255);

      start_cfg(7, 3);
      push_run("rst_mid", 7, 3, 0, 8, len);
      run_cycles(len, 1, 0);
      rst_n = 1'b0;
      #1;
      check("rst_async", 32'({en, busy, done, cfg_ready}), 32'h1);
      @(negedge clk);
      check("rst_hold", 32'({en, busy, done, cfg_ready}), 32'h1);
      rst_n = 1'b1;
      push_idle("post_rst", 20);
      run_cycles(20, 0, 0);

      start_cfg(2, 2);
      push_run("after_rst", 2, 2, 0, 0, len);
      run_cycles(len, 1, 0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
